// File: rtl/rf_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : rf_scrubber
// Purpose  : Background ECC scrubber that walks the register file using idle
//            RF read/write port cycles. Define RF_SCRUB_CNT_EN to build the
//            corrected-error counter.
// Revision : 1.0
// ============================================================================
module rf_scrubber #(
   parameter int IDLE_WAIT = 16,
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_enable_i,
   input  logic        s_op_rp_busy_i,
   input  logic        s_wb_we_i,
   input  logic [4:0]  s_wb_rd_i,
   input  logic        s_rf_ce_i,
   input  logic        s_rf_uce_i,
   input  logic [31:0] s_rf_cval_i,
   output logic        s_scrub_rreq_o,
   output logic [4:0]  s_scrub_radd_o,
   output logic        s_scrub_we_o,
   output logic [4:0]  s_scrub_wadd_o,
   output logic [31:0] s_scrub_wval_o,
   output logic        s_busy_o,
   output logic        s_uce_o,
   output logic [15:0] s_ce_cnt_o
);

   localparam int                  c_WAIT_W    = (IDLE_WAIT > 1) ? $clog2(IDLE_WAIT) : 1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(IDLE_WAIT - 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
   localparam logic [4:0]          c_FIRST     = 5'(FIRST_REG);
   localparam logic [4:0]          c_LAST      = 5'(LAST_REG);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_CHECK = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_WAIT_W-1:0] r_wait;
   logic [4:0]          r_addr;
   logic [31:0]         r_cval;
   logic                r_uce;

   logic                w_grant;
   logic                w_stale;
   logic                w_write_done;
   logic [4:0]          w_addr_next;

   assign w_grant      = (r_state == ST_READ) & ~s_op_rp_busy_i;
   // A WB write to the address being scrubbed makes the read value obsolete.
   assign w_stale      = s_wb_we_i & (s_wb_rd_i == r_addr);
   assign w_write_done = (r_state == ST_WRITE) & ~s_wb_we_i;
   assign w_addr_next  = (r_addr == c_LAST) ? c_FIRST : r_addr + 5'd1;

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         r_state <= ST_IDLE;
         r_wait  <= '0;
         r_addr  <= c_FIRST;
         r_cval  <= '0;
         r_uce   <= 1'b0;
      end else begin
         r_uce <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!s_enable_i) begin
                  r_wait <= '0;
               end else if (r_wait == c_WAIT_LAST) begin
                  r_wait  <= '0;
                  r_state <= ST_READ;
               end else begin
                  r_wait <= r_wait + c_WAIT_ONE;
               end
            end
            ST_READ: begin
               if (w_grant) begin
                  r_state <= ST_CHECK;
               end else if (!s_enable_i) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_CHECK: begin
               if (s_rf_uce_i) begin
                  r_uce   <= 1'b1;
                  r_addr  <= w_addr_next;
                  r_state <= ST_IDLE;
               end else if (w_stale || !s_rf_ce_i) begin
                  r_addr  <= w_addr_next;
                  r_state <= ST_IDLE;
               end else begin
                  r_cval  <= s_rf_cval_i;
                  r_state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (w_write_done || w_stale) begin
                  r_addr  <= w_addr_next;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef RF_SCRUB_CNT_EN
   logic [15:0] r_ce_cnt;

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         r_ce_cnt <= '0;
      end else if (w_write_done && (r_ce_cnt != 16'hFFFF)) begin
         r_ce_cnt <= r_ce_cnt + 16'd1;
      end
   end

   assign s_ce_cnt_o = r_ce_cnt;
`else
   assign s_ce_cnt_o = 16'h0;
`endif

   assign s_scrub_rreq_o = (r_state == ST_READ);
   assign s_scrub_radd_o = r_addr;
   assign s_scrub_we_o   = w_write_done;
   assign s_scrub_wadd_o = r_addr;
   assign s_scrub_wval_o = r_cval;
   assign s_busy_o       = (r_state != ST_IDLE);
   assign s_uce_o        = r_uce;

endmodule
`default_nettype wire

// File: tb/tb_rf_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_scrubber
// Purpose  : Directed, table-driven bench for rf_scrubber (honours RF_SCRUB_CNT_EN).
// Revision : 1.0
// ============================================================================
module tb_rf_scrubber;

   localparam int IDLE_WAIT = 4;
`ifdef RF_SCRUB_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        op_busy = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic        rf_ce = 1'b0;
   logic        rf_uce = 1'b0;
   logic [31:0] rf_cval = 32'd0;

   logic        rreq, we, busy, uce;
   logic [4:0]  radd, wadd;
   logic [31:0] wval;
   logic [15:0] cnt;

   rf_scrubber #(
      .IDLE_WAIT (IDLE_WAIT),
      .FIRST_REG (1),
      .LAST_REG  (31)
   ) dut (
      .s_clk_i        (clk),
      .s_reset_i      (rst),
      .s_enable_i     (enable),
      .s_op_rp_busy_i (op_busy),
      .s_wb_we_i      (wb_we),
      .s_wb_rd_i      (wb_rd),
      .s_rf_ce_i      (rf_ce),
      .s_rf_uce_i     (rf_uce),
      .s_rf_cval_i    (rf_cval),
      .s_scrub_rreq_o (rreq),
      .s_scrub_radd_o (radd),
      .s_scrub_we_o   (we),
      .s_scrub_wadd_o (wadd),
      .s_scrub_wval_o (wval),
      .s_busy_o       (busy),
      .s_uce_o        (uce),
      .s_ce_cnt_o     (cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int we_cycles = 0;
   int uce_cycles = 0;
   logic [15:0] exp_cnt = 16'd0;

   always @(negedge clk) begin
      if (we)  we_cycles++;
      if (uce) uce_cycles++;
   end

   typedef struct {
      logic [4:0]  addr;
      int          busy_cyc;
      int          wbw_cyc;
      bit          ce;
      bit          uce;
      bit          stale_chk;
      bit          wb_other;
      bit          stale_wr;
      logic [31:0] cval;
      bit          exp_write;
      bit          exp_uce;
   } vec_t;

   vec_t tbl [38];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_ctl"}, {28'd0, rreq, we, busy, uce}, 32'd0);
      chk({name, "_radd"}, {27'd0, radd}, 32'd1);
      chk({name, "_wadd"}, {27'd0, wadd}, 32'd1);
      chk({name, "_wval"}, wval, 32'd0);
      chk({name, "_cnt"}, {16'd0, cnt}, 32'd0);
   endtask

   function automatic vec_t clean(input int a);
      vec_t v;
      v.addr = 5'(a); v.busy_cyc = 0; v.wbw_cyc = 0;
      v.ce = 0; v.uce = 0; v.stale_chk = 0; v.wb_other = 0; v.stale_wr = 0;
      v.cval = 32'd0; v.exp_write = 0; v.exp_uce = 0;
      return v;
   endfunction

   task automatic wait_rreq(input int exp_gap);
      int n = 0;
      while (rreq !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("idle_gap", n, exp_gap);
   endtask

   // One complete scrub of v.addr; ends on the second IDLE cycle afterwards.
   task automatic run_op(input vec_t v, input int exp_gap);
      int         we0, uce0;
      bit         in_write;
      logic [4:0] nxt;
      wait_rreq(exp_gap);
      chk("radd", {27'd0, radd}, {27'd0, v.addr});
      we0  = we_cycles;
      uce0 = uce_cycles;
      in_write = v.exp_write | v.stale_wr;
      nxt = (v.addr == 5'd31) ? 5'd1 : v.addr + 5'd1;
      if (v.busy_cyc > 0) begin
         op_busy = 1'b1;
         for (int i = 0; i < v.busy_cyc; i++) tick();
         chk("rreq_held", {30'd0, rreq, busy}, 32'd3);
         op_busy = 1'b0;
      end
      tick();
      rf_ce = v.ce; rf_uce = v.uce; rf_cval = v.cval;
      if (v.stale_chk) begin
         wb_we = 1'b1; wb_rd = v.addr;
      end else if (v.wb_other) begin
         wb_we = 1'b1; wb_rd = v.addr ^ 5'h10;
      end
      tick();
      rf_ce = 1'b0; rf_uce = 1'b0; rf_cval = 32'd0; wb_we = 1'b0; wb_rd = 5'd0;
      chk("uce_now", {31'd0, uce}, {31'd0, v.exp_uce});
      chk("post_check_busy", {31'd0, busy}, {31'd0, in_write});
      if (in_write) begin
         for (int i = 0; i < v.wbw_cyc; i++) begin
            wb_we = 1'b1; wb_rd = v.addr ^ 5'h10;
            #1;
            chk("we_yield", {31'd0, we}, 32'd0);
            tick();
         end
         if (v.stale_wr) begin
            wb_we = 1'b1; wb_rd = v.addr;
            #1;
            chk("we_stale", {31'd0, we}, 32'd0);
            tick();
         end else begin
            wb_we = 1'b0;
            #1;
            chk("we", {31'd0, we}, 32'd1);
            chk("wadd", {27'd0, wadd}, {27'd0, v.addr});
            chk("wval", wval, v.cval);
            tick();
         end
         wb_we = 1'b0; wb_rd = 5'd0;
      end
      if (CNT_EN && v.exp_write && exp_cnt != 16'hFFFF) exp_cnt++;
      tick();
      chk("idle_after", {31'd0, busy}, 32'd0);
      chk("next_addr", {27'd0, radd}, {27'd0, nxt});
      chk("write_cycles", we_cycles - we0, {31'd0, v.exp_write});
      chk("uce_cycles", uce_cycles - uce0, {31'd0, v.exp_uce});
      chk("ce_cnt", {16'd0, cnt}, {16'd0, exp_cnt});
   endtask

   initial begin
      int we_base;
      for (int i = 0; i < 38; i++) tbl[i] = clean((i % 31) + 1);
      tbl[1].busy_cyc = 10;
      tbl[2].ce = 1; tbl[2].cval = 32'hCAFE0003; tbl[2].wbw_cyc = 3; tbl[2].exp_write = 1;
      tbl[3].uce = 1; tbl[3].exp_uce = 1;
      tbl[4].ce = 1; tbl[4].cval = 32'hDEADBEEF; tbl[4].exp_write = 1;
      tbl[5].ce = 1; tbl[5].uce = 1; tbl[5].cval = 32'h66666666; tbl[5].exp_uce = 1;
      tbl[6].ce = 1; tbl[6].cval = 32'h77777777; tbl[6].stale_wr = 1;
      tbl[7].ce = 1; tbl[7].cval = 32'h88888888; tbl[7].stale_chk = 1;
      tbl[8].ce = 1; tbl[8].cval = 32'h99999999; tbl[8].wb_other = 1; tbl[8].exp_write = 1;
      tbl[30].ce = 1; tbl[30].cval = 32'hA5A50031; tbl[30].exp_write = 1;
      tbl[37].uce = 1; tbl[37].exp_uce = 1;

      // Reset state, then a reset landing on a pending write.
      tick(); tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      enable = 1'b1;
      wait_rreq(IDLE_WAIT);
      tick();
      rf_ce = 1'b1; rf_cval = 32'h11112222;
      tick();
      rf_ce = 1'b0; rf_cval = 32'd0;
      wb_we = 1'b1; wb_rd = 5'd20;
      #1;
      chk("pending_write_busy", {30'd0, busy, we}, 32'd2);
      we_base = we_cycles;
      rst = 1'b1;
      #1;
      chk_reset_outputs("async_reset");
      wb_we = 1'b0; wb_rd = 5'd0;
      tick(); tick();
      rst = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("no_write_after_reset", we_cycles - we_base, 32'd0);
      chk("reset_addr_kept", {27'd0, radd}, 32'd1);

      // Sweep with wrap, contention, CE/UCE/stale cases.
      enable = 1'b1;
      for (int i = 0; i < 38; i++) run_op(tbl[i], (i == 0) ? IDLE_WAIT : IDLE_WAIT - 1);

      // Enable dropped while the read request is blocked.
      op_busy = 1'b1;
      wait_rreq(IDLE_WAIT - 1);
      chk("drop_radd", {27'd0, radd}, 32'd8);
      enable = 1'b0;
      tick();
      chk("drop_to_idle", {30'd0, busy, rreq}, 32'd0);
      chk("drop_addr_kept", {27'd0, radd}, 32'd8);
      op_busy = 1'b0;
      enable = 1'b1;
      tick(); tick();
      enable = 1'b0;
      tick(); tick(); tick();
      chk("disabled_idle", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      wait_rreq(IDLE_WAIT);

      // Enable dropped after grant: the write still completes.
      we_base = we_cycles;
      tick();
      enable = 1'b0;
      rf_ce = 1'b1; rf_cval = 32'h12345678;
      tick();
      rf_ce = 1'b0; rf_cval = 32'd0;
      #1;
      chk("late_drop_we", {31'd0, we}, 32'd1);
      chk("late_drop_wadd", {27'd0, wadd}, 32'd8);
      chk("late_drop_wval", wval, 32'h12345678);
      if (CNT_EN) exp_cnt++;
      for (int i = 0; i < 10; i++) tick();
      chk("late_drop_writes", we_cycles - we_base, 32'd1);
      chk("late_drop_addr", {27'd0, radd}, 32'd9);
      chk("late_drop_idle", {30'd0, busy, rreq}, 32'd0);
      chk("late_drop_cnt", {16'd0, cnt}, {16'd0, exp_cnt});

`ifdef RF_SCRUB_CNT_EN
      force dut.r_ce_cnt = 16'hFFFE;
      #1;
      release dut.r_ce_cnt;
      exp_cnt = 16'hFFFE;
      enable = 1'b1;
      begin
         vec_t v;
         v = clean(9);  v.ce = 1; v.cval = 32'h0000FFFF; v.exp_write = 1;
         run_op(v, IDLE_WAIT);
         v = clean(10); v.ce = 1; v.cval = 32'h00010000; v.exp_write = 1;
         run_op(v, IDLE_WAIT - 1);
      end
      chk("cnt_saturated", {16'd0, cnt}, 32'h0000FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
